hazard_stall_unit: RTL

- Producer side of the operand-forwarding interface. Tracks the destination register, result source and remaining Tnew of every in-flight instruction through the E, M and W stages.
- Publishes A3_E/Res_E, A3_M/Res_M and A3_W/Res_W to the forwarding mux controller.
- Compares each stage's Tnew against the Tuse of the instruction in D. When forwarding cannot cover a dependency, it stalls F/D and injects a bubble into E.
- Also owns the mult/div busy counter and stalls HI/LO users while that counter runs.

---
 rtl/hazard_stall_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// hazard_stall_unit : E/M/W destination tracking, Tnew/Tuse stall, md busy
// Rev 1.0
// ============================================================================
module hazard_stall_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A1_D,
  input  logic [4:0] A2_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] A3_D,
  input  logic [1:0] Res_D,
  input  logic       md_use_D,
  input  logic       md_start_E,
  input  logic       md_div_E,
  output logic [4:0] A3_E,
  output logic [4:0] A3_M,
  output logic [4:0] A3_W,
  output logic [1:0] Res_E,
  output logic [1:0] Res_M,
  output logic [1:0] Res_W,
  output logic       stall,
  output logic       PC_en,
  output logic       D_en,
  output logic       E_clr,
  output logic       md_busy
);

  localparam logic [1:0] RES_NW  = 2'b00;
  localparam logic [1:0] RES_ALU = 2'b01;
  localparam logic [1:0] RES_DM  = 2'b10;

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);

  logic [4:0]       a3_e_q, a3_m_q, a3_w_q, a3_e_d;
  logic [1:0]       res_e_q, res_m_q, res_w_q, res_e_d;
  logic [1:0]       tnew_e_q, tnew_m_q, tnew_e_d, tnew_m_d, tnew_dec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_rs, stall_rt, stall_md;

  // Tnew at E entry: cycles until the result exists in a forwardable latch.
  always_comb begin
    case (Res_D)
      RES_ALU: tnew_dec_d = 2'd1;
      RES_DM:  tnew_dec_d = 2'd2;
      default: tnew_dec_d = 2'd0;
    endcase
  end

  always_comb begin
    a3_e_d   = A3_D;
    res_e_d  = Res_D;
    tnew_e_d = tnew_dec_d;
    if (stall) begin
      a3_e_d   = 5'd0;
      res_e_d  = RES_NW;
      tnew_e_d = 2'd0;
    end
    tnew_m_d = (tnew_e_q != 2'd0) ? (tnew_e_q - 2'd1) : 2'd0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (md_start_E) begin
      cnt_d = md_div_E ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a3_e_q   <= 5'd0;
      res_e_q  <= RES_NW;
      tnew_e_q <= 2'd0;
      a3_m_q   <= 5'd0;
      res_m_q  <= RES_NW;
      tnew_m_q <= 2'd0;
      a3_w_q   <= 5'd0;
      res_w_q  <= RES_NW;
      cnt_q    <= '0;
    end else begin
      a3_e_q   <= a3_e_d;
      res_e_q  <= res_e_d;
      tnew_e_q <= tnew_e_d;
      a3_m_q   <= a3_e_q;
      res_m_q  <= res_e_q;
      tnew_m_q <= tnew_m_d;
      a3_w_q   <= a3_m_q;
      res_w_q  <= res_m_q;
      cnt_q    <= cnt_d;
    end
  end

  // Register 0 never carries a real dependency; Tuse=3 is never below any Tnew.
  assign stall_rs = (A1_D != 5'd0) &&
                    (((A1_D == a3_e_q) && (Tuse_rs_D < tnew_e_q)) ||
                     ((A1_D == a3_m_q) && (Tuse_rs_D < tnew_m_q)));
  assign stall_rt = (A2_D != 5'd0) &&
                    (((A2_D == a3_e_q) && (Tuse_rt_D < tnew_e_q)) ||
                     ((A2_D == a3_m_q) && (Tuse_rt_D < tnew_m_q)));
  assign stall_md = md_use_D && (md_start_E || md_busy);

  assign stall   = stall_rs || stall_rt || stall_md;
  assign PC_en   = ~stall;
  assign D_en    = ~stall;
  assign E_clr   = stall;
  assign md_busy = (cnt_q != '0);

  assign A3_E  = a3_e_q;
  assign A3_M  = a3_m_q;
  assign A3_W  = a3_w_q;
  assign Res_E = res_e_q;
  assign Res_M = res_m_q;
  assign Res_W = res_w_q;

endmodule
`default_nettype wire
